hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Each cycle, drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC hold.
- Resolves four conditions: load-use hazards, taken branches, data-memory wait states, and a fixed-latency multi-cycle multiply held in EX.
- Also provides stall and flush performance counters.

Parameters:
- MUL_LATENCY, 4, total cycles a multiply occupies EX; legal range is 2 or more.
- COUNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- exMemRead  in  1  the instruction in EX is a load.
- exRd  in  5  destination register of the instruction in EX.
- branchTaken  in  1  a branch or jump resolved taken in EX.
- mulStart  in  1  the instruction in EX is a multiply.
- memReq  in  1  the MEM stage is issuing a data access.
- memReady  in  1  data memory completes the access this cycle.
- pcStall  out  1  hold the PC.
- ifIdStall  out  1  stall IF/ID.
- ifIdFlush  out  1  flush IF/ID.
- idExStall  out  1  stall ID/EX.
- idExFlush  out  1  flush ID/EX (inject a bubble).
- exMemStall  out  1  stall EX/MEM.
- exMemFlush  out  1  flush EX/MEM.
- memWbFlush  out  1  flush MEM/WB.
- mulDone  out  1  one-cycle pulse; the multiply result is valid in EX this cycle.
- busy  out  1  FSM is not in RUN.
- stallCycles  out  COUNT_WIDTH  number of cycles with pcStall=1.
- flushCount  out  COUNT_WIDTH  number of cycles with ifIdFlush=1.

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. Counters and the FSM are registered.

Reset:
- While reset=1, all 1-bit outputs are 0.
- Next state is RUN, the multiply counter is 0, and both performance counters are 0.
- Reset during MUL_BUSY returns the FSM to RUN with no mulDone pulse.

Derived terms:
- memStall = memReq & ~memReady.
- loadUse = exMemRead & (exRd != 0) & ((exRd == idRs) | (exRd == idRt)).

Priority, highest first:
1. reset
2. memStall
3. MUL_BUSY stall
4. branchTaken
5. mulStart
6. loadUse

Exactly one of these sets the outputs in a given cycle. Any output not listed for the active case is 0.

Outputs per case:
- memStall (in any state): pcStall = ifIdStall = idExStall = exMemStall = 1, memWbFlush = 1. The FSM does not leave MUL_BUSY during a memStall cycle, but the multiply counter still decrements (floor 0).
- branchTaken in RUN: ifIdFlush = 1, idExFlush = 1. The PC is not stalled. Any loadUse or mulStart in the same cycle is ignored.
- mulStart in RUN: pcStall = ifIdStall = idExStall = 1, exMemFlush = 1. The counter is loaded with MUL_LATENCY-2 and the next state is MUL_BUSY.
- loadUse in RUN: pcStall = ifIdStall = 1, idExFlush = 1 (exactly one bubble). The state stays RUN.

MUL_BUSY:
- While the counter is not 0: assert the same outputs as mulStart and decrement the counter.
- When the counter is 0 and memStall=0: all stalls are 0, mulDone=1, next state RUN.
- Total EX occupancy is MUL_LATENCY cycles when there are no memory waits.
- mulStart, branchTaken and loadUse are ignored while in MUL_BUSY.

busy:
- busy = 1 exactly when the state is MUL_BUSY.

Performance counters:
- stallCycles increments on every cycle with pcStall=1.
- flushCount increments on every cycle with ifIdFlush=1.
- Both saturate at all-ones and never wrap.

Test Plan:
1. Load-use: exMemRead=1, exRd=5, idRs=5 for one cycle -> pcStall=ifIdStall=idExFlush=1 for exactly 1 cycle; stallCycles=1. Repeat with exRd=0 -> no stall.
2. Branch beats load-use: branchTaken=1 together with a matching loadUse -> ifIdFlush=idExFlush=1, pcStall=0; flushCount increments by 1.
3. Multiply with MUL_LATENCY=4: mulStart=1 for one cycle -> stalls asserted for 3 cycles, mulDone=1 in cycle 4, busy=1 in cycles 2-4; stallCycles=3.
4. Memory wait during multiply: memReady=0 for 5 cycles starting at multiply cycle 2 -> mulDone is delayed until the first cycle with memReady=1; memWbFlush=1 throughout the wait; no glitch on mulDone.
5. Reset mid-multiply: reset=1 in multiply cycle 2 -> next cycle state is RUN, busy=0, counters 0, and mulDone never pulses.
6. Counter saturation with COUNT_WIDTH=4: 20 consecutive stall cycles -> stallCycles holds at 15.

Source files
------------

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits, multi-cycle
// multiply occupancy, taken branches and load-use hazards, and counts stalls/flushes.
module hazard_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             idRs,
  input  logic [4:0]             idRt,
  input  logic                   exMemRead,
  input  logic [4:0]             exRd,
  input  logic                   branchTaken,
  input  logic                   mulStart,
  input  logic                   memReq,
  input  logic                   memReady,
  output logic                   pcStall,
  output logic                   ifIdStall,
  output logic                   ifIdFlush,
  output logic                   idExStall,
  output logic                   idExFlush,
  output logic                   exMemStall,
  output logic                   exMemFlush,
  output logic                   memWbFlush,
  output logic                   mulDone,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] stallCycles,
  output logic [COUNT_WIDTH-1:0] flushCount
);

  localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  // The first multiply cycle is spent in RUN and the last one raises mulDone.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] mul_cnt, mul_cnt_next;
  logic             mem_stall;
  logic             load_use;

  assign mem_stall = memReq & ~memReady;
  assign load_use  = exMemRead & (exRd != 5'd0) & ((exRd == idRs) | (exRd == idRt));

  // NOTE: every output and next-state value gets a default first, so no path through
  // the priority chain can leave a signal unassigned and infer a latch.
  always_comb begin
    pcStall      = 1'b0;
    ifIdStall    = 1'b0;
    ifIdFlush    = 1'b0;
    idExStall    = 1'b0;
    idExFlush    = 1'b0;
    exMemStall   = 1'b0;
    exMemFlush   = 1'b0;
    memWbFlush   = 1'b0;
    mulDone      = 1'b0;
    state_next   = state;
    mul_cnt_next = mul_cnt;

    if (!reset) begin
      if (mem_stall) begin
        pcStall    = 1'b1;
        ifIdStall  = 1'b1;
        idExStall  = 1'b1;
        exMemStall = 1'b1;
        memWbFlush = 1'b1;
        // The multiply keeps computing while the memory side is frozen.
        if (mul_cnt != '0) mul_cnt_next = mul_cnt - CNT_W'(1);
      end else if (state == MUL_BUSY) begin
        if (mul_cnt != '0) begin
          pcStall      = 1'b1;
          ifIdStall    = 1'b1;
          idExStall    = 1'b1;
          exMemFlush   = 1'b1;
          mul_cnt_next = mul_cnt - CNT_W'(1);
        end else begin
          mulDone    = 1'b1;
          state_next = RUN;
        end
      end else if (branchTaken) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end else if (mulStart) begin
        pcStall      = 1'b1;
        ifIdStall    = 1'b1;
        idExStall    = 1'b1;
        exMemFlush   = 1'b1;
        mul_cnt_next = MUL_LOAD;
        state_next   = MUL_BUSY;
      end else if (load_use) begin
        pcStall   = 1'b1;
        ifIdStall = 1'b1;
        idExFlush = 1'b1;
      end
    end
  end

  assign busy = (state == MUL_BUSY) & ~reset;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (pcStall && (stallCycles != '1)) stallCycles <= stallCycles + COUNT_WIDTH'(1);
      if (ifIdFlush && (flushCount != '1)) flushCount <= flushCount + COUNT_WIDTH'(1);
    end
  end

endmodule
